// File: rtl/oldland_mem_arbiter.sv
// oldland_mem_arbiter
//   Merges the CPU instruction-refill bus and data bus onto one shared
//   memory/peripheral port. One master is granted per transaction. A bus
//   timeout turns a dead slave into an error response so the pipeline
//   never hangs.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no transaction; arbitrate and latch the winner into m_*
//   GRANT_I   | instruction master owns the shared port
//   GRANT_D   | data master owns the shared port
//   RECOVER   | one dead cycle so the finished master can drop its request
//
// Parameters
//   TIMEOUT_CYCLES  grant cycles without m_ack/m_error before a timeout
//                   error (2..65535)
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   i_access/i_addr              instruction read request
//   i_data/i_ack/i_error         instruction response (ack/error pulses)
//   d_access/d_addr/d_bytesel/
//   d_wr_en/d_wr_val             data request and attributes
//   d_data/d_ack/d_error         data response (ack/error pulses)
//   m_access/m_addr/m_bytesel/
//   m_wr_en/m_wr_val             registered shared-port request
//   m_data/m_ack/m_error         shared-port slave response
//
// Configuration
//   OLDLAND_MEM_ARBITER_ROUND_ROBIN_EN  when defined, simultaneous requests
//   are granted to the master not granted last (I wins the first tie).
//   When undefined, data has fixed priority over instruction.
module oldland_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_access,
  input  logic [29:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_ack,
  output logic        i_error,
  input  logic        d_access,
  input  logic [29:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,
  output logic        m_access,
  output logic [29:0] m_addr,
  output logic [3:0]  m_bytesel,
  output logic        m_wr_en,
  output logic [31:0] m_wr_val,
  input  logic [31:0] m_data,
  input  logic        m_ack,
  input  logic        m_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_I = 2'd1;
  localparam logic [1:0] S_GRANT_D = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             granted;
  logic             timeout_hit;
  logic             done;
  logic             resp_ok;
  logic             resp_err;
  logic             grant_d;
  logic             grant_i;

  assign granted     = (state == S_GRANT_I) || (state == S_GRANT_D);
  // A slave response in the final cycle takes precedence over the timeout.
  assign timeout_hit = granted && !m_ack && !m_error && (cnt == CNT_LAST);
  assign done        = granted && (m_ack || m_error || timeout_hit);
  // Responses are suppressed while rst is high so an aborted transfer
  // never produces a pulse.
  assign resp_ok     = granted && m_ack && !m_error && !rst;
  assign resp_err    = granted && (m_error || timeout_hit) && !rst;

`ifdef OLDLAND_MEM_ARBITER_ROUND_ROBIN_EN
  logic last_grant_d;
  assign grant_d = d_access && (!i_access || !last_grant_d);
`else
  assign grant_d = d_access;
`endif
  assign grant_i = i_access && !grant_d;

  assign i_ack   = resp_ok  && (state == S_GRANT_I);
  assign i_error = resp_err && (state == S_GRANT_I);
  assign d_ack   = resp_ok  && (state == S_GRANT_D);
  assign d_error = resp_err && (state == S_GRANT_D);
  assign i_data  = (state == S_GRANT_I) ? m_data : 32'h0;
  assign d_data  = (state == S_GRANT_D) ? m_data : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      m_access  <= 1'b0;
      m_addr    <= 30'h0;
      m_bytesel <= 4'h0;
      m_wr_en   <= 1'b0;
      m_wr_val  <= 32'h0;
`ifdef OLDLAND_MEM_ARBITER_ROUND_ROBIN_EN
      last_grant_d <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (grant_d) begin
            state     <= S_GRANT_D;
            m_access  <= 1'b1;
            m_addr    <= d_addr;
            m_bytesel <= d_bytesel;
            m_wr_en   <= d_wr_en;
            m_wr_val  <= d_wr_val;
`ifdef OLDLAND_MEM_ARBITER_ROUND_ROBIN_EN
            last_grant_d <= 1'b1;
`endif
          end else if (grant_i) begin
            state     <= S_GRANT_I;
            m_access  <= 1'b1;
            m_addr    <= i_addr;
            m_bytesel <= 4'hf;
            m_wr_en   <= 1'b0;
            m_wr_val  <= 32'h0;
`ifdef OLDLAND_MEM_ARBITER_ROUND_ROBIN_EN
            last_grant_d <= 1'b0;
`endif
          end
        end
        S_GRANT_I, S_GRANT_D: begin
          if (done) begin
            state    <= S_RECOVER;
            m_access <= 1'b0;
            cnt      <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RECOVER: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oldland_mem_arbiter.sv
module tb_oldland_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_access = 1'b0;
  logic [29:0] i_addr = 30'h0;
  logic [31:0] i_data;
  logic        i_ack, i_error;
  logic        d_access = 1'b0;
  logic [29:0] d_addr = 30'h0;
  logic [3:0]  d_bytesel = 4'h0;
  logic        d_wr_en = 1'b0;
  logic [31:0] d_wr_val = 32'h0;
  logic [31:0] d_data;
  logic        d_ack, d_error;
  logic        m_access;
  logic [29:0] m_addr;
  logic [3:0]  m_bytesel;
  logic        m_wr_en;
  logic [31:0] m_wr_val;
  logic [31:0] m_data = 32'h0;
  logic        m_ack = 1'b0;
  logic        m_error = 1'b0;

  int total = 0;
  int passed = 0;
  int fails = 0;
  // Reference model: did the most recent grant go to the data master?
  bit last_was_d = 1'b1;

  always #5 clk = ~clk;

  oldland_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_access(i_access), .i_addr(i_addr), .i_data(i_data),
    .i_ack(i_ack), .i_error(i_error),
    .d_access(d_access), .d_addr(d_addr), .d_bytesel(d_bytesel),
    .d_wr_en(d_wr_en), .d_wr_val(d_wr_val), .d_data(d_data),
    .d_ack(d_ack), .d_error(d_error),
    .m_access(m_access), .m_addr(m_addr), .m_bytesel(m_bytesel),
    .m_wr_en(m_wr_en), .m_wr_val(m_wr_val), .m_data(m_data),
    .m_ack(m_ack), .m_error(m_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction starting in an IDLE cycle. delay = response
  // cycle index within the grant (>= TO means the slave never answers);
  // kind 0 = ack, 1 = error, 2 = ack+error; late = stray m_ack in RECOVER.
  task automatic txn(input bit req_i, input bit req_d, input int delay, input int kind,
                     input bit late, input logic [31:0] rdata);
    bit won_d, resp, done, exp_ack;
    logic [29:0] ea;
    logic [3:0]  eb;
    logic        ew;
    logic [31:0] ev;
    if (req_i) i_access = 1'b1;
    if (req_d) d_access = 1'b1;
`ifdef OLDLAND_MEM_ARBITER_ROUND_ROBIN_EN
    if (i_access && d_access) won_d = !last_was_d;
    else won_d = d_access;
`else
    won_d = d_access;
`endif
    last_was_d = won_d;
    ea = won_d ? d_addr : i_addr;
    eb = won_d ? d_bytesel : 4'hf;
    ew = won_d ? d_wr_en : 1'b0;
    ev = won_d ? d_wr_val : 32'h0;
    @(posedge clk); #1;
    chk("grant_access", 64'(m_access), 64'd1);
    chk("grant_addr", 64'(m_addr), 64'(ea));
    chk("grant_bytesel", 64'(m_bytesel), 64'(eb));
    chk("grant_wr_en", 64'(m_wr_en), 64'(ew));
    chk("grant_wr_val", 64'(m_wr_val), 64'(ev));
    done = 1'b0;
    for (int k = 0; k < TO && !done; k++) begin
      resp    = (k == delay);
      m_ack   = resp && (kind != 1);
      m_error = resp && (kind != 0);
      m_data  = rdata;
      @(negedge clk);
      if (resp || k == TO - 1) begin
        done    = 1'b1;
        exp_ack = resp && (kind == 0);
        if (won_d) begin
          chk("d_ack", 64'(d_ack), 64'(exp_ack));
          chk("d_error", 64'(d_error), 64'(!exp_ack));
          chk("d_data", 64'(d_data), 64'(rdata));
          chk("i_quiet", 64'({i_ack, i_error}), 64'd0);
          chk("i_data_zero", 64'(i_data), 64'd0);
        end else begin
          chk("i_ack", 64'(i_ack), 64'(exp_ack));
          chk("i_error", 64'(i_error), 64'(!exp_ack));
          chk("i_data", 64'(i_data), 64'(rdata));
          chk("d_quiet", 64'({d_ack, d_error}), 64'd0);
          chk("d_data_zero", 64'(d_data), 64'd0);
        end
        chk("held_addr", 64'(m_addr), 64'(ea));
      end else begin
        chk("no_early_resp", 64'({i_ack, i_error, d_ack, d_error}), 64'd0);
      end
      @(posedge clk); #1;
      m_ack   = 1'b0;
      m_error = 1'b0;
      if (!done) chk("access_held", 64'(m_access), 64'd1);
    end
    chk("released", 64'(m_access), 64'd0);
    if (won_d) d_access = 1'b0;
    else i_access = 1'b0;
    if (late) begin
      m_ack  = 1'b1;
      m_data = $urandom;
    end
    @(negedge clk);
    chk("recover_quiet", 64'({i_ack, i_error, d_ack, d_error}), 64'd0);
    chk("recover_data", 64'({i_data, d_data}), 64'd0);
    @(posedge clk); #1;
    m_ack = 1'b0;
    chk("recover_idle", 64'(m_access), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset with both masters requesting.
    i_access  = 1'b1;
    i_addr    = 30'h2a0;
    d_access  = 1'b1;
    d_addr    = 30'h100;
    d_bytesel = 4'b0011;
    d_wr_en   = 1'b1;
    d_wr_val  = 32'hdeadbeef;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_access", 64'(m_access), 64'd0);
      chk("rst_attrs", 64'({m_addr, m_bytesel, m_wr_en}), 64'd0);
      chk("rst_resp", 64'({i_ack, i_error, d_ack, d_error}), 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // Contention straight out of reset; the D grant is the directed write
    // (slave acks 2 cycles after m_access rises).
    txn(1'b1, 1'b1, 2, 0, 1'b0, 32'h0badf00d);
    txn(1'b1, 1'b1, 0, 0, 1'b0, 32'h11110000);
    for (int n = 0; n < 4; n++)
      txn(1'b1, 1'b1, $urandom_range(0, 2), 0, 1'b0, $urandom);
    while (i_access || d_access)
      txn(1'b0, 1'b0, 1, 0, 1'b0, $urandom);

    // Single instruction read, immediate ack.
    i_addr = 30'h40;
    txn(1'b1, 1'b0, 0, 0, 1'b0, 32'h12345678);

    // Timeout on a data read, then a late ack while idle.
    d_addr    = 30'h3;
    d_bytesel = 4'h1;
    d_wr_en   = 1'b0;
    d_wr_val  = 32'h0;
    txn(1'b0, 1'b1, TO, 0, 1'b0, 32'h0);
    m_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_idle", 64'({i_ack, i_error, d_ack, d_error}), 64'd0);
    @(posedge clk); #1;
    m_ack = 1'b0;
    chk("late_ack_no_grant", 64'(m_access), 64'd0);

    // ack and error together, with a stray ack in RECOVER.
    txn(1'b0, 1'b1, 1, 2, 1'b1, 32'hcafe0001);

    // Reset during an instruction grant.
    i_addr   = 30'h55;
    i_access = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_grant", 64'({m_access, m_bytesel}), 64'h1f);
    rst    = 1'b1;
    m_ack  = 1'b1;
    m_data = 32'h77777777;
    @(negedge clk);
    chk("rstmid_no_resp", 64'({i_ack, i_error, d_ack, d_error}), 64'd0);
    @(posedge clk); #1;
    chk("rstmid_access", 64'(m_access), 64'd0);
    rst        = 1'b0;
    m_ack      = 1'b0;
    i_access   = 1'b0;
    last_was_d = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      bit ri, rd;
      ri = $urandom_range(0, 1) != 0;
      rd = $urandom_range(0, 1) != 0;
      if (!ri && !rd && !i_access && !d_access) rd = 1'b1;
      if (ri && !i_access) i_addr = 30'($urandom);
      if (rd && !d_access) begin
        d_addr    = 30'($urandom);
        d_bytesel = 4'($urandom_range(0, 14));
        d_wr_en   = $urandom_range(0, 1) != 0;
        d_wr_val  = $urandom;
      end
      txn(ri, rd, $urandom_range(0, TO), $urandom_range(0, 2),
          $urandom_range(0, 1) != 0, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
